// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage responder for a 5-stage RV32I pipeline.
//
// Takes the EX/MEM fields, runs a variable-latency req/ack access to data memory,
// stalls upstream while the access is outstanding, formats load data, generates
// store byte enables and registers the result toward MEM/WB.
//
// Optional feature macro: MEM_TIMEOUT_EN. When defined, a WAIT that sees no ack
// for TIMEOUT_CYCLES cycles is aborted and bus_err pulses; when undefined no
// counter is built and bus_err is tied low.
//
// Ports:
//   clk, reset              clock (rising edge), async active-low reset
//   is_load_in/is_store_in  memory op flags; is_nop_in marks a bubble
//   sub_op_in               funct3 (width / signedness)
//   daddr_in, r_rv2_in      byte address and store data
//   rd_in, reg_wdata_in,
//   rwe_in                  non-memory write-back fields
//   dmem_*                  data memory request/response
//   stall_mem               freeze IF..EX/MEM while high
//   rd_out, reg_wdata_out,
//   rwe_out                 registered MEM/WB fields
//   misalign_err, bus_err   one-cycle error pulses
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        is_load_in,
  input  logic        is_store_in,
  input  logic        is_nop_in,
  input  logic [2:0]  sub_op_in,
  input  logic [31:0] daddr_in,
  input  logic [31:0] r_rv2_in,
  input  logic [4:0]  rd_in,
  input  logic [31:0] reg_wdata_in,
  input  logic        rwe_in,
  output logic        dmem_req,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_we,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_mem,
  output logic [4:0]  rd_out,
  output logic [31:0] reg_wdata_out,
  output logic        rwe_out,
  output logic        misalign_err,
  output logic        bus_err
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e      state_q;
  logic        req_q;
  logic [31:0] addr_q;
  logic [3:0]  we_q;
  logic [31:0] wdata_q;
  logic [4:0]  rd_q;
  logic [31:0] res_q;
  logic        rwe_q;
  logic        mis_q;
  logic        timeout_hit;

  // Access decode
  logic        mem_op;
  logic        do_store;
  logic        sz_byte;
  logic        sz_half;
  logic        misaligned;
  logic [3:0]  st_we;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign mem_op   = !is_nop_in && (is_load_in || is_store_in);
  assign do_store = is_store_in && !is_load_in;

  // LBU/LHU encodings exist only for loads; any other code falls back to word.
  assign sz_byte = (sub_op_in == 3'b000) || (is_load_in && sub_op_in == 3'b100);
  assign sz_half = (sub_op_in == 3'b001) || (is_load_in && sub_op_in == 3'b101);

  assign misaligned = sz_byte ? 1'b0 :
                      sz_half ? daddr_in[0] :
                                (daddr_in[1:0] != 2'b00);

  always_comb begin
    st_we    = 4'b1111;
    st_wdata = r_rv2_in;
    if (sz_byte) begin
      st_we    = 4'b0001 << daddr_in[1:0];
      st_wdata = {4{r_rv2_in[7:0]}};
    end else if (sz_half) begin
      st_we    = daddr_in[1] ? 4'b1100 : 4'b0011;
      st_wdata = {2{r_rv2_in[15:0]}};
    end
  end

  always_comb begin
    ld_byte = dmem_rdata[7:0];
    unique case (daddr_in[1:0])
      2'd0: ld_byte = dmem_rdata[7:0];
      2'd1: ld_byte = dmem_rdata[15:8];
      2'd2: ld_byte = dmem_rdata[23:16];
      2'd3: ld_byte = dmem_rdata[31:24];
      default: ld_byte = dmem_rdata[7:0];
    endcase
    ld_half = daddr_in[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    ld_data = dmem_rdata;
    if (sz_byte) begin
      ld_data = sub_op_in[2] ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
    end else if (sz_half) begin
      ld_data = sub_op_in[2] ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic [TO_W-1:0] cnt_q;
  logic            bus_err_q;

  assign timeout_hit = (state_q == StWait) && !dmem_ack &&
                       (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign bus_err     = bus_err_q;
`else
  logic unused_cfg;

  assign unused_cfg  = ^{TIMEOUT_CYCLES[0], TO_W[0]};
  assign timeout_hit = 1'b0;
  assign bus_err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      req_q     <= 1'b0;
      addr_q    <= '0;
      we_q      <= '0;
      wdata_q   <= '0;
      rd_q      <= '0;
      res_q     <= '0;
      rwe_q     <= 1'b0;
      mis_q     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
`endif
    end else begin
      mis_q     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      bus_err_q <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (mem_op && !misaligned) begin
            state_q <= StWait;
            req_q   <= 1'b1;
            addr_q  <= {daddr_in[31:2], 2'b00};
            we_q    <= do_store ? st_we : 4'b0000;
            wdata_q <= st_wdata;
            rd_q    <= '0;
            res_q   <= '0;
            rwe_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end else if (mem_op) begin
            mis_q <= 1'b1;
            rd_q  <= '0;
            res_q <= '0;
            rwe_q <= 1'b0;
          end else begin
            rd_q  <= is_nop_in ? 5'd0 : rd_in;
            rwe_q <= is_nop_in ? 1'b0 : rwe_in;
            res_q <= reg_wdata_in;
          end
        end
        StWait: begin
          if (dmem_ack) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            we_q    <= '0;
            if (is_load_in) begin
              rd_q  <= rd_in;
              res_q <= ld_data;
              rwe_q <= 1'b1;
            end else begin
              rd_q  <= '0;
              res_q <= '0;
              rwe_q <= 1'b0;
            end
          end else if (timeout_hit) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            we_q    <= '0;
            rd_q    <= '0;
            res_q   <= '0;
            rwe_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            bus_err_q <= 1'b1;
`endif
          end else begin
`ifdef MEM_TIMEOUT_EN
            cnt_q <= cnt_q + 1'b1;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Stall is combinational so the request cycle itself already freezes upstream.
  assign stall_mem = (state_q == StIdle) ? (mem_op && !misaligned)
                                         : (!dmem_ack && !timeout_hit);

  assign dmem_req      = req_q;
  assign dmem_addr     = addr_q;
  assign dmem_we       = we_q;
  assign dmem_wdata    = wdata_q;
  assign rd_out        = rd_q;
  assign reg_wdata_out = res_q;
  assign rwe_out       = rwe_q;
  assign misalign_err  = mis_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage responder for the 5-stage RV32I pipeline.
- Consumes the EX/MEM state fields: address, store data, load/store flags, sub_op (funct3), rd, write-back data and rwe.
- Runs a variable-latency req/ack transaction to external data memory, stalling upstream stages until the access completes.
- Formats load data (byte/half/word, sign/zero extension), generates store byte enables, and registers the result toward MEM/WB.

Parameters:
- TIMEOUT_CYCLES, 255, max WAIT cycles before abort (only with MEM_TIMEOUT_EN).
- TO_W, 8, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- is_load_in  in  1  load instruction in MEM.
- is_store_in  in  1  store instruction in MEM.
- is_nop_in  in  1  bubble; no access, no write-back.
- sub_op_in  in  3  funct3: LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101.
- daddr_in  in  32  byte address from ALU.
- r_rv2_in  in  32  store data.
- rd_in  in  5  destination register.
- reg_wdata_in  in  32  non-memory write-back value.
- rwe_in  in  1  non-memory register write enable.
- dmem_req  out  1  access request; high throughout WAIT.
- dmem_addr  out  32  word-aligned address, {daddr[31:2],2'b00}.
- dmem_we  out  4  byte write enables; 0000 for loads.
- dmem_wdata  out  32  store data, lane-replicated.
- dmem_rdata  in  32  read word; valid when dmem_ack is high.
- dmem_ack  in  1  completion strobe; may arrive in the first WAIT cycle.
- stall_mem  out  1  freeze IF..EX/MEM; upstream holds all inputs stable while high.
- rd_out  out  5  MEM/WB destination.
- reg_wdata_out  out  32  MEM/WB write data.
- rwe_out  out  1  MEM/WB write enable.
- misalign_err  out  1  one-cycle pulse on a misaligned access.
- bus_err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (reset=0, async): state IDLE; dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0; rd_out=0, reg_wdata_out=0, rwe_out=0; misalign_err=0, bus_err=0; timeout counter=0.
- mem_op = !is_nop_in & (is_load_in | is_store_in).
- Misaligned condition: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
- FSM: two states, IDLE and WAIT.
- IDLE, mem_op, aligned:
  - stall_mem=1 (combinational).
  - Next edge: register dmem_addr, dmem_we and dmem_wdata; go to WAIT.
  - Registered outputs load a bubble: rwe_out=0, rd_out=0.
- IDLE, mem_op, misaligned:
  - No request, no stall.
  - Next edge: misalign_err=1 for one cycle; bubble written to MEM/WB.
- IDLE, otherwise: 1-cycle passthrough of rd_in/reg_wdata_in/rwe_in. A nop forces rd_out=0 and rwe_out=0.
- WAIT:
  - dmem_req=1; addr, we and wdata held constant.
  - stall_mem = !dmem_ack.
  - On ack, next edge returns to IDLE and registers the result:
    - Loads: rwe_out=1, rd_out=rd_in, reg_wdata_out=formatted data.
    - Stores: rwe_out=0, rd_out=0.
- Load format: pick the byte at addr[1:0] or the half at addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- Store enables:
  - SB: 0001<<addr[1:0], wdata={4{rv2[7:0]}}.
  - SH: 0011<<(2*addr[1]), wdata={2{rv2[15:0]}}.
  - SW: 1111, wdata=rv2.
- Undefined sub_op on a memory operation: treated as word width.
- Reset asserted during WAIT: dmem_req drops immediately; the access is abandoned; state IDLE.
- An ack seen in IDLE is ignored.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - Counter clears on IDLE->WAIT and increments each WAIT cycle without ack.
  - When count reaches TIMEOUT_CYCLES with no ack: next edge returns to IDLE, bus_err pulses for one cycle, bubble written (rwe_out=0), stall_mem releases that cycle.
- MEM_TIMEOUT_EN undefined:
  - No counter is built.
  - WAIT persists until ack; bus_err is tied to 0.

Test Plan:
- LW daddr=0x100, ack in the 3rd WAIT cycle with rdata=0xDEADBEEF, rd=5 -> dmem_addr=0x100, we=0000; stall_mem high for 3 cycles; then rd_out=5, rwe_out=1, reg_wdata_out=0xDEADBEEF.
- LB daddr=0x103, rdata=0x80FF_1234 -> 0xFFFFFF80. LBU at the same address -> 0x00000080. LHU daddr=0x102 -> 0x000080FF.
- SH daddr=0x202, rv2=0x0000ABCD, same-cycle ack -> dmem_we=1100, dmem_wdata=0xABCDABCD, dmem_addr=0x200; stall_mem high 1 cycle; rwe_out=0.
- LW daddr=0x101 -> no dmem_req, stall_mem=0, misalign_err pulses once, rwe_out=0.
- ADD passthrough (rwe_in=1, rd=7, data=0x55) followed by a nop -> rd_out=7/data 0x55 next cycle, then rd_out=0 and rwe_out=0.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, SW with no ack -> bus_err pulses after 4 WAIT cycles and the FSM returns to IDLE. Separately, drive reset low mid-WAIT -> dmem_req=0 and all outputs 0 immediately.
